// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills instruction memory and gates core reset
module imem_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Word count at which the memory is full; one more byte is an overflow.
  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] WC_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [1:0]              lane_q, lane_d;
  logic [23:0]             pack_q, pack_d;
  logic [ADDR_WIDTH:0]     wc_q, wc_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic                    hold_q, hold_d;

  logic                    loading;
  logic                    accept;
  logic                    start_load;
  logic                    full;
  logic                    overflow;
  logic                    last_byte;
  logic                    word_done;
  logic [WORD_WIDTH-1:0]   word_asm;

  // Handshake qualifiers shared by the FSM and the datapath.
  assign loading    = (state_q == S_LOAD);
  assign accept     = in_valid & loading;
  assign start_load = start & ~loading;
  assign full       = (wc_q == CAPACITY);
  assign overflow   = accept & full;
  assign last_byte  = accept & ~full & in_last;
  assign word_done  = accept & ~full & ((lane_q == 2'd3) | in_last);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is honoured outside LOAD, a final or overflowing byte ends the load.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (overflow || last_byte) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    if (state_q == S_LOAD) begin
      in_ready = 1'b1;
      busy     = 1'b1;
    end
    if (state_q == S_DONE) begin
      done = 1'b1;
    end
  end

  // Merge the incoming byte into its lane; lanes above it are still zero, which zero-fills short words.
  always_comb begin
    word_asm = {8'h00, pack_q};
    unique case (lane_q)
      2'd0:    word_asm[7:0]   = in_data;
      2'd1:    word_asm[15:8]  = in_data;
      2'd2:    word_asm[23:16] = in_data;
      default: word_asm[31:24] = in_data;
    endcase
  end

  // Datapath next-state: packing, write issue, word counting, error and core hold.
  always_comb begin
    lane_d  = lane_q;
    pack_d  = pack_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    if (start_load) begin
      lane_d = 2'd0;
      pack_d = 24'h0;
      wc_d   = '0;
      err_d  = 1'b0;
    end else if (overflow) begin
      // Byte beyond capacity is dropped without a write.
      err_d = 1'b1;
    end else if (accept) begin
      if (word_done) begin
        we_d    = 1'b1;
        addr_d  = wc_q[ADDR_WIDTH-1:0];
        wdata_d = word_asm;
        wc_d    = wc_q + WC_ONE;
        lane_d  = 2'd0;
        pack_d  = 24'h0;
        if (in_last && (lane_q != 2'd3)) begin
          err_d = 1'b1;
        end
      end else begin
        lane_d = lane_q + 2'd1;
        pack_d = word_asm[23:0];
      end
    end

    // Release the core only once DONE has lasted a full cycle, so the last write has committed.
    hold_d = !((state_q == S_DONE) && (state_d == S_DONE));
  end

  // Datapath registers; reset also squashes any pending write pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q  <= 2'd0;
      pack_q  <= 24'h0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign error      = err_q;
  assign core_hold  = hold_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with a word-level reference model
module tb_imem_loader;

  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int         total = 0;
  int         bad   = 0;
  wr_t        exp_q[$];
  logic [7:0] prog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse is matched against the next expected write.
  always @(negedge clk) begin
    if (!reset) begin
      chk("we_in_reset", {31'h0, mem_we}, 32'h0);
    end else if (mem_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write act=addr %0d data %h exp=no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {30'h0, mem_addr}, {30'h0, e.addr});
        chk("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Reference: words are consecutive 4-byte groups, little-endian, zero-filled,
  // limited to capacity; a stream longer than capacity overflows on its next byte.
  task automatic run_load(input int n, input bit has_last, input int maxgap);
    int  nw;
    bit  ovf;
    bit  comp;
    ovf = !has_last && (n > 4 * CAP);
    nw  = has_last ? (n + 3) / 4 : n / 4;
    if (nw > CAP) nw = CAP;
    for (int k = 0; k < nw; k++) begin
      wr_t e;
      e.addr = AW'(k);
      e.data = 32'h0;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < n) e.data = e.data | (32'(prog[4 * k + j]) << (8 * j));
      end
      exp_q.push_back(e);
    end

    start = 1'b1;
    if ($urandom_range(0, 1) == 1) begin
      in_valid = 1'b1;
      in_data  = prog[0];
      in_last  = has_last && (n == 1);
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    chk("start_busy", {31'h0, busy}, 32'h1);
    chk("start_wc", {29'h0, word_count}, 32'h0);
    chk("start_err", {31'h0, error}, 32'h0);
    chk("start_hold", {31'h0, core_hold}, 32'h1);

    for (int i = 0; i < n; i++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      send_byte(prog[i], has_last && (i == n - 1));
      comp = (i < 4 * CAP) && ((i % 4 == 3) || (has_last && (i == n - 1)));
      chk("we_timing", {31'h0, mem_we}, {31'h0, comp});
    end

    if (has_last || ovf) begin
      chk("done_first", {31'h0, done}, 32'h1);
      chk("hold_first", {31'h0, core_hold}, 32'h1);
      chk("ready_done", {31'h0, in_ready}, 32'h0);
      @(negedge clk);
      chk("hold_fall", {31'h0, core_hold}, 32'h0);
      chk("done_held", {31'h0, done}, 32'h1);
      chk("word_count", {29'h0, word_count}, 32'(nw));
      chk("error", {31'h0, error}, {31'h0, ovf || (has_last && (n % 4 != 0))});
      chk("pending_writes", 32'(exp_q.size()), 32'h0);
    end
  endtask

  task automatic set_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;

    // Reset with random inputs.
    repeat (3) begin
      @(negedge clk);
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
    end
    chk("rst_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_addr", {30'h0, mem_addr}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_hold", {31'h0, core_hold}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, error}, 32'h0);
    chk("rst_wc", {29'h0, word_count}, 32'h0);
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("idle_hold", {31'h0, core_hold}, 32'h1);

    // Basic program, no gaps.
    prog = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    run_load(8, 1'b1, 0);

    // Same program with handshake gaps (start from DONE).
    run_load(8, 1'b1, 3);

    // Truncated final word.
    prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_load(6, 1'b1, 1);

    // Overflow: one byte beyond capacity without in_last.
    set_prog(4 * CAP + 1);
    run_load(4 * CAP + 1, 1'b0, 1);

    // Reset mid-load after six bytes.
    set_prog(6);
    run_load(6, 1'b0, 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_wc", {29'h0, word_count}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("mid_rst_hold", {31'h0, core_hold}, 32'h1);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    chk("mid_rst_pending", 32'(exp_q.size()), 32'h0);

    // Restart from IDLE, then from DONE.
    set_prog(7);
    run_load(7, 1'b1, 2);
    set_prog(5);
    run_load(5, 1'b1, 0);

    // Randomized loads.
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_prog(4 * CAP + 1);
        run_load(4 * CAP + 1, 1'b0, $urandom_range(0, 3));
      end else begin
        int n;
        n = $urandom_range(1, 4 * CAP);
        set_prog(n);
        run_load(n, 1'b1, $urandom_range(0, 3));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("final_pending", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. It fills instruction memory from a byte stream so the datapath can run a program without the simulation-time memory preload.
- Accepts bytes over a valid/ready handshake and packs them little-endian into 32-bit words.
- Issues one write per word, incrementing from word address 0.
- Holds the core in reset until the program is fully committed.

Parameters:
- ADDR_WIDTH, 5, word-address width; capacity = 2^ADDR_WIDTH words (32 by default, matching instruction memory).
- WORD_WIDTH, 32, memory word width; fixed at 4 bytes and not otherwise supported.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle request to begin a load; sampled in IDLE or DONE.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  program byte.
- in_last  input  1  qualifies the final byte of the program; meaningful only when in_valid=1.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction-memory write enable; one-cycle pulse per word.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  assembled word.
- core_hold  output  1  holds the datapath/PC in reset while 1.
- busy  output  1  1 while in LOAD.
- done  output  1  1 while in DONE.
- error  output  1  sticky flag: truncated final word or overflow.
- word_count  output  ADDR_WIDTH+1  number of words written in the current load.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, core_hold=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, word_count=0, byte lane=0.
- Reset never touches memory contents. Words already written before a reset are retained.
- States: IDLE, LOAD, DONE. in_ready = busy = (state==LOAD); done = (state==DONE).
- IDLE -> LOAD on start=1. On that edge: word_count=0, lane=0, error=0, core_hold=1.
- DONE -> LOAD on start=1, with the same clearing as IDLE -> LOAD.
- start is ignored while in LOAD.
- A byte is accepted on an edge where in_valid && in_ready. The byte goes to lane L: lane0 -> bits[7:0], lane3 -> bits[31:24]. L then increments mod 4.
- No byte is accepted in the cycle the state enters LOAD from a start; in_ready first rises the cycle after.
- Word completion occurs on the edge that accepts lane 3, or a byte with in_last=1. On that edge:
  - mem_we is registered to 1 for exactly the following cycle.
  - mem_addr = word_count[ADDR_WIDTH-1:0].
  - mem_wdata = packed word.
  - word_count increments.
- Memory commits on the edge that ends the mem_we cycle.
- Truncated last word: in_last on lane L<3 zero-fills lanes L+1..3, writes the partial word, and sets error=1.
- Back-to-back bytes at full rate are allowed. in_ready stays 1 during the write cycle (no bubble), and the packing register for the next word is cleared on the completing edge.
- in_last on the completing edge moves the state to DONE on that same edge. In the first DONE cycle, mem_we=1 and done=1.
- core_hold is registered and falls on the edge following the first DONE cycle, i.e. after the final word is committed.
- Overflow: a byte accepted when word_count == 2^ADDR_WIDTH is dropped with no write; error=1 and the state goes to DONE.
- Reaching capacity without in_last keeps the state in LOAD; only a further byte triggers overflow.
- core_hold=1 from reset and during LOAD. It is 0 only in DONE, from the second DONE cycle onward.
- Simultaneous start and in_valid in IDLE/DONE: start takes effect; the byte is not accepted (in_ready=0).
- Reset mid-load: returns to IDLE immediately. The partial word is discarded; a pending mem_we is squashed asynchronously.

Test Plan:
- Reset values: hold reset=0 for 3 cycles with random inputs -> all outputs at reset values, mem_we never 1, core_hold=1.
- Basic load, no gaps: start, then bytes 93,00,10,00,13,01,20,00 with in_last on the 8th -> two writes: addr0=0x00100093, addr1=0x00200113. word_count=2, done=1, error=0; core_hold falls one cycle after done rises.
- Handshake gaps: same bytes with in_valid dropping for 1-3 random cycles -> identical writes and timing relative to accepted bytes; no write in idle cycles.
- Truncation: bytes AA,BB,CC,DD,EE,FF with in_last on FF -> addr0=0xDDCCBBAA, addr1=0x0000FFEE, error=1, word_count=2.
- Overflow (ADDR_WIDTH=2): 17 bytes without in_last -> 4 writes to addrs 0-3; the 17th byte is dropped, error=1, DONE, word_count=4.
- Reset mid-load, then restart: assert reset after 6 bytes -> IDLE, no further writes, addr0 word retained. Then start from IDLE, and later start from DONE -> word_count and error clear, core_hold reasserts, addressing restarts at 0.
